dmu_sio_outbound_rcv: RTL
=========================

// Module: dmu_sio_outbound_rcv
// PURPOSE
//  DMU-side receiver for the SIU->DMU outbound interface. Captures the header
//  cycle (sio_dmu_hdr_vld) and, when sio_dmu_datareq is asserted with it,
//  captures the PLD_BEATS-beat payload (64 B) that follows.
//  Checks per-lane parity and protocol framing. Presents registered header and
//  payload beats to the DMU core, plus error flags and saturating counters.
// PARAMETERS
//  PLD_BEATS  4   payload beats per data packet (128 b each); legal range 2..8
//  PAR_ODD    0   0: even parity, 1: odd parity per 16-bit lane
//  CNT_W      16  width of the statistic counters
// PORTS
//  iol2clk        in   1      clock; all logic on posedge
//  rst            in   1      synchronous reset, active-high
//  sio_dmu_hdr_vld in  1      header cycle strobe
//  sio_dmu_datareq in  1      with hdr_vld: payload follows; without: write ack only
//  sio_dmu_data   in   128    header or payload word
//  sio_dmu_parity in   8      parity[i] covers data[16i+15:16i]
//  hdr_out        out  128    captured header
//  hdr_out_vld    out  1      1-cycle pulse: hdr_out valid
//  hdr_has_pld    out  1      qualifies hdr_out_vld: payload will follow
//  pld_out        out  128    captured payload beat
//  pld_out_vld    out  1      1-cycle pulse per payload beat
//  pld_out_beat   out  3      beat index 0..PLD_BEATS-1
//  pld_out_last   out  1      with pld_out_vld: final beat of packet
//  par_err        out  1      1-cycle pulse: parity error on a captured cycle
//  proto_err      out  1      1-cycle pulse: framing violation
//  pkt_cnt        out  CNT_W  completed packets (acks + full data packets), saturating
//  err_cnt        out  CNT_W  par_err + proto_err events, saturating
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs, counters and beat counter are 0.
//  - Latency: every output reflects the input cycle 1 clock earlier (registered).
//  - Lane check: exp[i] = ^data[16i+15:16i] ^ PAR_ODD. Error if parity[i]!=exp[i]
//    for any i. Checked only on header and payload cycles. Idle cycles are ignored.
//  - FSM IDLE: hdr_vld=1 -> hdr_out_vld, hdr_has_pld=datareq.
//      datareq=1 -> PLD, beat=0. datareq=0 -> stay IDLE and pkt_cnt+1 (ack).
//      hdr_vld=0 and datareq=1 -> proto_err, stay IDLE, nothing captured.
//  - FSM PLD: every cycle is a payload beat (contiguous, no gaps).
//      Emit pld_out_vld with pld_out_beat=beat, then beat+1.
//      beat==PLD_BEATS-1 -> pld_out_last=1, pkt_cnt+1, go to IDLE.
//  - hdr_vld during PLD: proto_err. The partial packet is dropped: no last, no pkt_cnt.
//    That cycle is treated as a new header with IDLE rules, same cycle. Beat resets to 0.
//  - datareq=1 in PLD without hdr_vld: ignored (data word still a beat).
//  - Back-to-back: a header in the cycle after a last beat is legal, no bubble.
//  - par_err and proto_err in the same cycle: both pulse, err_cnt +2 (saturating).
//  - Counters saturate at all-ones, never wrap.
//  - A parity error does not alter the FSM. The data is forwarded and flagged only.
//  - rst mid-packet: FSM to IDLE. Any pulse outputs scheduled for the next cycle
//    are suppressed (0).
// TESTING
//  - Ack: hdr_vld=1, datareq=0, data=0x1234 with good parity -> next cycle
//    hdr_out_vld=1, hdr_has_pld=0, hdr_out=0x1234, pkt_cnt=1.
//  - Data pkt: hdr+datareq, then beats D0..D3 -> hdr_out_vld, then 4 pld_out_vld.
//    beat 0..3, last only on beat 3, pkt_cnt=1.
//  - Parity: flip parity[5] on beat 2 -> par_err pulse with beat 2 only.
//    Packet completes, err_cnt=1.
//  - Abort: new header at beat 1 -> proto_err. No last for the first packet.
//    The new packet completes normally, pkt_cnt=1.
//  - Orphan datareq in IDLE -> proto_err, no vld outputs. Back-to-back packets
//    -> no bubble between last and next hdr_out_vld.
//  - Saturation: CNT_W=4, 20 acks -> pkt_cnt=15. rst asserted mid-payload ->
//    all outputs 0 next cycle, FSM back to IDLE.

Source files
------------

// File: rtl/dmu_sio_outbound_rcv.sv
// SIU->DMU outbound receiver: captures header and payload cycles, checks lane
// parity and packet framing, and keeps saturating packet/error statistics.
module dmu_sio_outbound_rcv #(
   parameter int       PLD_BEATS = 4,
   parameter bit       PAR_ODD   = 1'b0,
   parameter int       CNT_W     = 16
) (
   input  logic             iol2clk,
   input  logic             rst,
   input  logic             sio_dmu_hdr_vld,
   input  logic             sio_dmu_datareq,
   input  logic [127:0]     sio_dmu_data,
   input  logic [7:0]       sio_dmu_parity,
   output logic [127:0]     hdr_out,
   output logic             hdr_out_vld,
   output logic             hdr_has_pld,
   output logic [127:0]     pld_out,
   output logic             pld_out_vld,
   output logic [2:0]       pld_out_beat,
   output logic             pld_out_last,
   output logic             par_err,
   output logic             proto_err,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [2:0] LAST_BEAT = 3'(PLD_BEATS - 1);

   typedef enum logic {ST_IDLE, ST_PLD} state_t;

   state_t     r_state;
   logic [2:0] r_beat;

   logic [7:0] w_par_exp;
   logic       w_pld_cyc;
   logic       w_last;
   logic       w_par_err;
   logic       w_proto_err;
   logic       w_pkt_inc;
   logic [1:0] w_err_inc;

   always_comb begin
      w_par_exp = '0;
      for (int i = 0; i < 8; i++)
         w_par_exp[i] = (^sio_dmu_data[16*i +: 16]) ^ PAR_ODD;
   end

   // A header always wins over an in-flight payload beat in the same cycle.
   assign w_pld_cyc   = (r_state == ST_PLD) && !sio_dmu_hdr_vld;
   assign w_last      = w_pld_cyc && (r_beat == LAST_BEAT);
   assign w_par_err   = (sio_dmu_hdr_vld || w_pld_cyc) && (sio_dmu_parity != w_par_exp);
   assign w_proto_err = ((r_state == ST_IDLE) && !sio_dmu_hdr_vld && sio_dmu_datareq) ||
                        ((r_state == ST_PLD)  &&  sio_dmu_hdr_vld);
   assign w_pkt_inc   = (sio_dmu_hdr_vld && !sio_dmu_datareq) || w_last;
   assign w_err_inc   = {1'b0, w_par_err} + {1'b0, w_proto_err};

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   // NOTE: synchronous reset clears every register, so pulses computed from
   // the reset cycle's inputs never reach the outputs.
   always_ff @(posedge iol2clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_beat       <= '0;
         hdr_out      <= '0;
         hdr_out_vld  <= 1'b0;
         hdr_has_pld  <= 1'b0;
         pld_out      <= '0;
         pld_out_vld  <= 1'b0;
         pld_out_beat <= '0;
         pld_out_last <= 1'b0;
         par_err      <= 1'b0;
         proto_err    <= 1'b0;
         pkt_cnt      <= '0;
         err_cnt      <= '0;
      end else begin
         hdr_out_vld  <= sio_dmu_hdr_vld;
         hdr_has_pld  <= sio_dmu_hdr_vld && sio_dmu_datareq;
         pld_out_vld  <= w_pld_cyc;
         pld_out_last <= w_last;
         par_err      <= w_par_err;
         proto_err    <= w_proto_err;
         pkt_cnt      <= sat_add(pkt_cnt, {1'b0, w_pkt_inc});
         err_cnt      <= sat_add(err_cnt, w_err_inc);

         if (sio_dmu_hdr_vld)
            hdr_out <= sio_dmu_data;
         if (w_pld_cyc) begin
            pld_out      <= sio_dmu_data;
            pld_out_beat <= r_beat;
         end

         if (sio_dmu_hdr_vld) begin
            r_state <= sio_dmu_datareq ? ST_PLD : ST_IDLE;
            r_beat  <= '0;
         end else if (r_state == ST_PLD) begin
            if (w_last) begin
               r_state <= ST_IDLE;
               r_beat  <= '0;
            end else begin
               r_beat  <= r_beat + 3'd1;
            end
         end
      end
   end

endmodule
